// File: rtl/control_unit_if.sv
// control_unit_if: IR/condition inputs and the full control word between the control unit and the datapath.
interface control_unit_if;
  logic [31:0] ir;
  logic        con_ff;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout;
  logic MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, CONIn, OutPortIn;
  logic read, write;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  modport master (
    input  ir, con_ff,
    output PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout,
           MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, CONIn, OutPortIn,
           read, write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op
  );
  modport slave (
    output ir, con_ff,
    input  PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout,
           MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, CONIn, OutPortIn,
           read, write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: multicycle control FSM decoding state + ir[31:27] into the datapath control word.
// Optional STEP_EN macro adds a WAIT_STEP state that waits for a step pulse before every fetch.
module control_unit #(
  parameter int         MEM_WAIT = 0,
  parameter logic [4:0] ADD_OP   = 5'b00011
) (
  input  logic clk,
  input  logic clr,
  input  logic stop,
  input  logic step,
  control_unit_if.master bus,
  output logic run
);
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, RST, HALT, WAIT_STEP} state_t;
`ifdef STEP_EN
  localparam state_t START = WAIT_STEP;
`else
  localparam state_t START = T0;
`endif
  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  state_t s;
  logic [CW-1:0] cnt;
  logic [4:0] op;
  logic rr, imm, un, md, ld, ldi, st, br, jr, inp, outp, mfhi, mflo, hlt, nopc;
  logic mw_done, hold, last;
  assign op   = bus.ir[31:27];
  assign rr   = op inside {[5'd3:5'd10]};
  assign imm  = op inside {[5'd11:5'd13]};
  assign un   = op inside {5'd16, 5'd17};
  assign md   = op inside {5'd14, 5'd15};
  assign ld   = op == 5'd0;
  assign ldi  = op == 5'd1;
  assign st   = op == 5'd2;
  assign br   = op == 5'd18;
  assign jr   = op == 5'd19;
  assign inp  = op == 5'd21;
  assign outp = op == 5'd22;
  assign mfhi = op == 5'd23;
  assign mflo = op == 5'd24;
  assign hlt  = op == 5'd26;
  assign nopc = !(rr | imm | un | md | ld | ldi | st | br | jr | inp | outp | mfhi | mflo | hlt);
  // memory-read states stretch themselves by MEM_WAIT cycles before MDRIn fires
  assign mw_done = cnt == CW'(MEM_WAIT);
  assign hold    = (s == T1 || (s == T6 && ld)) && !mw_done;
  assign last = (s == T2 && nopc) || (s == T3 && (jr | inp | outp | mfhi | mflo)) ||
                (s == T4 && un) || (s == T5 && (rr | imm | ldi)) ||
                (s == T6 && (md | br)) || s == T7;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s   <= RST;
      cnt <= '0;
    end else if (s == RST) begin
      s <= START;
    end else if (s == WAIT_STEP) begin
      s <= stop ? HALT : step ? T0 : WAIT_STEP;
    end else if (s != HALT) begin
      cnt <= hold ? cnt + 1'b1 : '0;
      if (!hold)
        s <= (s == T2 && hlt) ? HALT : last ? (stop ? HALT : START) : state_t'(s + 4'd1);
    end
  end
  assign run            = !(s == RST || s == HALT);
  assign bus.PCout      = s == T0 || (s == T4 && br);
  assign bus.Zlowout    = (s == T1 && mw_done) || (s == T4 && un) ||
                          (s == T5 && (rr | imm | ldi | ld | st | md)) || (s == T6 && br);
  assign bus.Zhighout   = s == T6 && md;
  assign bus.MDRout     = s == T2 || (s == T7 && ld);
  assign bus.Cout       = (s == T4 && (imm | ldi | ld | st)) || (s == T5 && br);
  assign bus.In_Portout = s == T3 && inp;
  assign bus.LOout      = s == T3 && mflo;
  assign bus.HIout      = s == T3 && mfhi;
  assign bus.MARIn      = s == T0 || (s == T5 && (ld | st));
  assign bus.ZIn        = s == T0 || (s == T3 && un) ||
                          (s == T4 && (rr | imm | ldi | ld | st | md)) || (s == T5 && br);
  assign bus.PCIn       = (s == T1 && mw_done) || (s == T3 && jr) || (s == T6 && br && bus.con_ff);
  assign bus.MDRIn      = (s == T1 && mw_done) || (s == T6 && ((ld && mw_done) || st));
  assign bus.IRIn       = s == T2;
  assign bus.YIn        = (s == T3 && (rr | imm | ldi | ld | st | md)) || (s == T4 && br);
  assign bus.IncPC      = s == T0;
  assign bus.HiIn       = s == T6 && md;
  assign bus.LoIn       = s == T5 && md;
  assign bus.CIn        = 1'b0;
  assign bus.CONIn      = s == T3 && br;
  assign bus.OutPortIn  = s == T3 && outp;
  assign bus.read       = s == T1 || (s == T6 && ld);
  assign bus.write      = s == T7 && st;
  assign bus.Gra        = (s == T3 && (md | br | jr | inp | outp | mfhi | mflo)) || (s == T4 && un) ||
                          (s == T5 && (rr | imm | ldi)) || (s == T6 && st) || (s == T7 && ld);
  assign bus.Grb        = (s == T3 && (rr | imm | un | ldi | ld | st)) || (s == T4 && md);
  assign bus.Grc        = s == T4 && rr;
  assign bus.Rin        = (s == T3 && (inp | mfhi | mflo)) || (s == T4 && un) ||
                          (s == T5 && (rr | imm | ldi)) || (s == T7 && ld);
  assign bus.Rout       = (s == T3 && (rr | imm | un | md | br | jr | outp)) ||
                          (s == T4 && (rr | md)) || (s == T6 && st);
  assign bus.BAout      = s == T3 && (ldi | ld | st);
  assign bus.alu_op     = ((s == T4 && (rr | imm | md)) || (s == T3 && un)) ? op : ADD_OP;
endmodule
